clk_div_checker: RTL and testbench
==================================

Name: clk_div_checker

Overview:
- Measures a divided clock, such as an odd-ratio divider output, by sampling it as data in the sys_clk domain.
- Reports the measured period and high time in sys_clk cycles, and flags ratio and duty-cycle pass/fail against expected values.
- Acts as the receiving end of the divider chain: an on-chip self-check for divider blocks, readable by a test harness or LED/status logic.

Parameters:
- CNT_W, 16, width of the period/high-time counters and outputs.
- SYNC_STAGES, 2, flip-flop stages synchronising clk_in into sys_clk (minimum 2).
- EXP_PERIOD, 5, expected period of clk_in in sys_clk cycles.
- PERIOD_TOL, 0, allowed absolute deviation from EXP_PERIOD.
- TIMEOUT_CYC, 1000, maximum sys_clk cycles spent in ARM+MEAS before aborting.

Ports:
- sys_clk, input, 1, system clock; the only clock in the block.
- sys_rst_n, input, 1, asynchronous active-low reset.
- clk_in, input, 1, divided clock under test, treated as an asynchronous data signal.
- start, input, 1, single-cycle request to begin a measurement.
- busy, output, 1, high from the cycle after an accepted start until done.
- done, output, 1, one-cycle pulse when a result or timeout is ready.
- period, output, CNT_W, measured rise-to-rise period in sys_clk cycles.
- high_time, output, CNT_W, number of sys_clk cycles the synchronised clk_in was sampled high within that period.
- ratio_ok, output, 1, |period − EXP_PERIOD| ≤ PERIOD_TOL.
- duty_ok, output, 1, |2·high_time − period| ≤ 1.
- timeout, output, 1, last measurement aborted on timeout.

Behaviour:
- Reset: state IDLE. busy, done, period, high_time, ratio_ok, duty_ok and timeout are all 0. Synchroniser flops are 0. Reset asserted mid-measurement returns to IDLE immediately; no done pulse is issued.
- Synchroniser: clk_s is the last stage of the SYNC_STAGES chain. rise = clk_s & ~clk_s_d. rise has SYNC_STAGES+1 cycles of latency from a clk_in edge; this latency is common to both edges and cancels out in the measurement.
- FSM states:
  - IDLE: start=1 → ARM; clears timeout, ratio_ok and duty_ok; the timeout counter is set to 0. start is ignored in every other state.
  - ARM: waiting for the first rise. On rise → MEAS, with pcnt=1 and hcnt=1.
  - MEAS: each cycle without rise, pcnt+=1 and hcnt+=clk_s. Both counters saturate at all-ones. On rise → DONE: period←pcnt, high_time←hcnt, and ratio_ok/duty_ok are computed from the new values using CNT_W+1-bit arithmetic. This rise also serves as the start of nothing further; the measurement is single-shot.
  - DONE: done=1 for one cycle, busy=0, → IDLE.
- Timeout: a counter increments every cycle in ARM or MEAS. When it reaches TIMEOUT_CYC−1 without completion → DONE, with timeout=1, period=0, high_time=0, ratio_ok=0 and duty_ok=0.
  - If completion and timeout occur in the same cycle, completion wins.
- busy is 1 in ARM and MEAS only.
- All result outputs hold their values until the next accepted start. timeout, ratio_ok and duty_ok clear at that start; period and high_time update only at DONE.
- Holding start high continuously produces back-to-back measurements, one per IDLE visit.

Decomposition:
- Package clk_div_checker_pkg holds:
  - the state enum (IDLE, ARM, MEAS, DONE);
  - the default constants CNT_W, SYNC_STAGES and TIMEOUT_CYC;
  - a function abs_diff(a,b) used for the ratio and duty checks.
- Sub-module sync_rise_det (parameter STAGES) contains the synchroniser chain and rising-edge detector, with outputs clk_s and rise. It is reusable for other async inputs.

Test Plan:
- clk_in from a sys_clk-registered pattern of 3 cycles high / 2 cycles low, then start pulse → done after ≤ 2 periods + SYNC_STAGES+2 cycles; period=5, high_time=3, ratio_ok=1, duty_ok=1, timeout=0.
- Pattern of 4 high / 1 low, EXP_PERIOD=5 → period=5, high_time=4, ratio_ok=1, duty_ok=0.
- Pattern of 4 high / 3 low (divide-by-7) with EXP_PERIOD=5, PERIOD_TOL=1 → period=7, high_time=4, ratio_ok=0, duty_ok=1.
- clk_in held at 0, start pulse → busy for exactly TIMEOUT_CYC cycles, then done with timeout=1, period=0, high_time=0.
- sys_rst_n pulsed low while in MEAS, asynchronously between clock edges → all outputs are 0 in the same cycle, and no done pulse follows. A subsequent start measures normally.
- start pulsed again in ARM and in MEAS → ignored; exactly one done is produced and the results match the first request.

Source files
------------

// File: rtl/clk_div_checker_pkg.sv
// ============================================================================
//  Module   : clk_div_checker_pkg
//  Purpose  : Shared state encoding, default sizes and helpers for the
//             divided-clock checker.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package clk_div_checker_pkg;

    localparam int DEF_CNT_W       = 16;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_TIMEOUT_CYC = 1000;

    // Common width for the ratio/duty comparisons; wide enough for CNT_W+1.
    localparam int ABS_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [ABS_W-1:0] abs_diff(
        input logic [ABS_W-1:0] a,
        input logic [ABS_W-1:0] b
    );
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

`default_nettype wire

// File: rtl/clk_div_checker_sync_rise_det.sv
// ============================================================================
//  Module   : sync_rise_det
//  Purpose  : Multi-flop synchroniser for an asynchronous input plus a
//             rising-edge detector on the synchronised value.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_rise_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic clk_s,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              last_q;
    logic              last_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_in};
        last_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            last_q <= last_d;
        end
    end

    assign clk_s = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-1] & ~last_q;

endmodule

`default_nettype wire

// File: rtl/clk_div_checker.sv
// ============================================================================
//  Module   : clk_div_checker
//  Purpose  : Single-shot measurement of a divided clock's period and high
//             time in sys_clk cycles, with ratio and duty-cycle verdicts.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module clk_div_checker
    import clk_div_checker_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int EXP_PERIOD  = 5,
    parameter int PERIOD_TOL  = 0,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             clk_in,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             ratio_ok,
    output logic             duty_ok,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   pcnt_q, pcnt_d;
    logic [CNT_W-1:0]   hcnt_q, hcnt_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [CNT_W-1:0]   high_q, high_d;
    logic [31:0]        tcnt_q, tcnt_d;
    logic               ratio_ok_q, ratio_ok_d;
    logic               duty_ok_q, duty_ok_d;
    logic               timeout_q, timeout_d;
    logic               clk_s;
    logic               rise;
    logic               tmo_hit;

    sync_rise_det #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .d_in  (clk_in),
        .clk_s (clk_s),
        .rise  (rise)
    );

    always_comb begin
        state_d    = state_q;
        pcnt_d     = pcnt_q;
        hcnt_d     = hcnt_q;
        period_d   = period_q;
        high_d     = high_q;
        tcnt_d     = tcnt_q;
        ratio_ok_d = ratio_ok_q;
        duty_ok_d  = duty_ok_q;
        timeout_d  = timeout_q;
        tmo_hit    = (tcnt_q == 32'(TIMEOUT_CYC - 1));

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = ARM;
                    tcnt_d     = '0;
                    timeout_d  = 1'b0;
                    ratio_ok_d = 1'b0;
                    duty_ok_d  = 1'b0;
                end
            end
            ARM: begin
                tcnt_d = tcnt_q + 32'd1;
                // A rise here only opens the window; it is not a completion.
                if (tmo_hit) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                    period_d  = '0;
                    high_d    = '0;
                end else if (rise) begin
                    state_d = MEAS;
                    pcnt_d  = CNT_ONE;
                    hcnt_d  = CNT_ONE;
                end
            end
            MEAS: begin
                tcnt_d = tcnt_q + 32'd1;
                if (rise) begin
                    state_d    = DONE;
                    period_d   = pcnt_q;
                    high_d     = hcnt_q;
                    ratio_ok_d = abs_diff(ABS_W'(pcnt_q), ABS_W'(EXP_PERIOD))
                                 <= ABS_W'(PERIOD_TOL);
                    duty_ok_d  = abs_diff(ABS_W'({hcnt_q, 1'b0}), ABS_W'(pcnt_q))
                                 <= ABS_W'(1);
                end else if (tmo_hit) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                    period_d  = '0;
                    high_d    = '0;
                end else begin
                    if (pcnt_q != CNT_MAX) pcnt_d = pcnt_q + CNT_ONE;
                    if (clk_s && (hcnt_q != CNT_MAX)) hcnt_d = hcnt_q + CNT_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            pcnt_q     <= '0;
            hcnt_q     <= '0;
            period_q   <= '0;
            high_q     <= '0;
            tcnt_q     <= '0;
            ratio_ok_q <= 1'b0;
            duty_ok_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pcnt_q     <= pcnt_d;
            hcnt_q     <= hcnt_d;
            period_q   <= period_d;
            high_q     <= high_d;
            tcnt_q     <= tcnt_d;
            ratio_ok_q <= ratio_ok_d;
            duty_ok_q  <= duty_ok_d;
            timeout_q  <= timeout_d;
        end
    end

    assign busy      = (state_q == ARM) || (state_q == MEAS);
    assign done      = (state_q == DONE);
    assign period    = period_q;
    assign high_time = high_q;
    assign ratio_ok  = ratio_ok_q;
    assign duty_ok   = duty_ok_q;
    assign timeout   = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_clk_div_checker.sv
// ============================================================================
//  Module   : tb_clk_div_checker
//  Purpose  : Self-checking bench for clk_div_checker driven by programmable
//             high/low clk_in patterns, with a queue of expected results.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_clk_div_checker;

    localparam int CNT_W       = 16;
    localparam int SYNC_STAGES = 2;
    localparam int EXP_PERIOD  = 5;
    localparam int PERIOD_TOL  = 1;
    localparam int TIMEOUT_CYC = 64;

    typedef struct packed {
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] high;
        logic             ratio;
        logic             duty;
        logic             tmo;
    } res_t;

    logic             sys_clk   = 1'b0;
    logic             sys_rst_n = 1'b1;
    logic             clk_in    = 1'b0;
    logic             start     = 1'b0;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             ratio_ok;
    logic             duty_ok;
    logic             timeout;

    res_t sb[$];
    int   n_chk    = 0;
    int   n_pass   = 0;
    int   done_cnt = 0;
    int   pat_h    = 3;
    int   pat_l    = 2;
    int   pat_cnt  = 0;
    bit   pat_en   = 1'b0;

    int tab_h[7] = '{4, 4, 3, 2, 1, 2, 3};
    int tab_l[7] = '{1, 3, 3, 2, 1, 6, 2};

    clk_div_checker #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES),
        .EXP_PERIOD  (EXP_PERIOD),
        .PERIOD_TOL  (PERIOD_TOL),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clk_in    (clk_in),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .period    (period),
        .high_time (high_time),
        .ratio_ok  (ratio_ok),
        .duty_ok   (duty_ok),
        .timeout   (timeout)
    );

    always #5 sys_clk = ~sys_clk;

    // clk_in pattern: pat_h cycles high, pat_l cycles low, updated away from the sampling edge
    always @(negedge sys_clk) begin
        if (pat_en) begin
            clk_in  = (pat_cnt < pat_h);
            pat_cnt = (pat_cnt + 1 >= pat_h + pat_l) ? 0 : pat_cnt + 1;
        end else begin
            clk_in  = 1'b0;
            pat_cnt = 0;
        end
    end

    always @(negedge sys_clk) if (done === 1'b1) done_cnt++;

    function automatic res_t cur_res();
        res_t r;
        r.period = period;
        r.high   = high_time;
        r.ratio  = ratio_ok;
        r.duty   = duty_ok;
        r.tmo    = timeout;
        return r;
    endfunction

    function automatic res_t model(int h, int l);
        res_t r;
        int   p;
        int   dr;
        int   dd;
        p  = h + l;
        dr = (p >= EXP_PERIOD) ? p - EXP_PERIOD : EXP_PERIOD - p;
        dd = (2 * h >= p) ? 2 * h - p : p - 2 * h;
        r.period = CNT_W'(p);
        r.high   = CNT_W'(h);
        r.ratio  = (dr <= PERIOD_TOL);
        r.duty   = (dd <= 1);
        r.tmo    = 1'b0;
        return r;
    endfunction

    task automatic set_pattern(int h, int l);
        pat_h  = h;
        pat_l  = l;
        pat_en = 1'b1;
        repeat (2 * (h + l) + 4) @(negedge sys_clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    task automatic wait_done(int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge sys_clk);
        end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b1;
        #1 sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        n_chk++;
        if ({busy, done, period, high_time, ratio_ok, duty_ok, timeout} !== '0)
            $display("FAIL reset_state: got busy=%b done=%b p=%0d h=%0d r=%b d=%b t=%b, want all 0",
                     busy, done, period, high_time, ratio_ok, duty_ok, timeout);
        else n_pass++;
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic test_ratio_duty();
        res_t e_res;
        res_t g_res;
        bit   ok;
        for (int i = 0; i < 7; i++) begin
            set_pattern(tab_h[i], tab_l[i]);
            sb.push_back(model(tab_h[i], tab_l[i]));
            pulse_start();
            n_chk++;
            if (busy !== 1'b1) $display("FAIL busy_after_start[%0d]: got %b want 1", i, busy);
            else n_pass++;
            wait_done(2 * (tab_h[i] + tab_l[i]) + SYNC_STAGES + 2, ok);
            e_res = sb.pop_front();
            g_res = cur_res();
            n_chk++;
            if (!ok || g_res !== e_res)
                $display("FAIL measure[%0d] %0dH/%0dL: got done=%b p=%0d h=%0d r=%b d=%b t=%b, want p=%0d h=%0d r=%b d=%b t=%b",
                         i, tab_h[i], tab_l[i], ok, g_res.period, g_res.high, g_res.ratio, g_res.duty, g_res.tmo,
                         e_res.period, e_res.high, e_res.ratio, e_res.duty, e_res.tmo);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        int   d0;
        res_t e_res;
        res_t g_res;
        bit   ok;
        set_pattern(3, 2);
        d0 = done_cnt;
        pulse_start();
        repeat (5) @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        n_chk++;
        if ({busy, done, period, high_time, ratio_ok, duty_ok, timeout} !== '0)
            $display("FAIL async_reset_outputs: got busy=%b done=%b p=%0d h=%0d r=%b d=%b t=%b, want all 0",
                     busy, done, period, high_time, ratio_ok, duty_ok, timeout);
        else n_pass++;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (15) @(negedge sys_clk);
        n_chk++;
        if (done_cnt != d0 || busy !== 1'b0)
            $display("FAIL no_done_after_reset: got dones=%0d busy=%b, want dones=0 busy=0", done_cnt - d0, busy);
        else n_pass++;
        sb.push_back(model(3, 2));
        pulse_start();
        wait_done(2 * 5 + SYNC_STAGES + 2, ok);
        e_res = sb.pop_front();
        g_res = cur_res();
        n_chk++;
        if (!ok || g_res !== e_res)
            $display("FAIL measure_after_reset: got done=%b p=%0d h=%0d r=%b d=%b t=%b, want p=%0d h=%0d r=%b d=%b t=%b",
                     ok, g_res.period, g_res.high, g_res.ratio, g_res.duty, g_res.tmo,
                     e_res.period, e_res.high, e_res.ratio, e_res.duty, e_res.tmo);
        else n_pass++;
    endtask

    task automatic test_timeout();
        res_t e_res;
        res_t g_res;
        int   cnt;
        pat_en = 1'b0;
        repeat (8) @(negedge sys_clk);
        sb.push_back(res_t'{CNT_W'(0), CNT_W'(0), 1'b0, 1'b0, 1'b1});
        pulse_start();
        // flags clear at start while the previous period/high_time (5/3) are held
        n_chk++;
        if ({ratio_ok, duty_ok, timeout} !== 3'b000 || period !== 5 || high_time !== 3)
            $display("FAIL hold_clear_at_start: got r=%b d=%b t=%b p=%0d h=%0d, want r=0 d=0 t=0 p=5 h=3",
                     ratio_ok, duty_ok, timeout, period, high_time);
        else n_pass++;
        cnt = 0;
        while (busy === 1'b1 && cnt < TIMEOUT_CYC + 8) begin
            cnt++;
            @(negedge sys_clk);
        end
        n_chk++;
        if (cnt != TIMEOUT_CYC) $display("FAIL timeout_busy_cycles: got %0d want %0d", cnt, TIMEOUT_CYC);
        else n_pass++;
        n_chk++;
        if (done !== 1'b1) $display("FAIL timeout_done: got %b want 1", done);
        else n_pass++;
        e_res = sb.pop_front();
        g_res = cur_res();
        n_chk++;
        if (g_res !== e_res)
            $display("FAIL timeout_result: got p=%0d h=%0d r=%b d=%b t=%b, want p=0 h=0 r=0 d=0 t=1",
                     g_res.period, g_res.high, g_res.ratio, g_res.duty, g_res.tmo);
        else n_pass++;
    endtask

    task automatic test_ignored_start();
        int   d0;
        res_t e_res;
        res_t g_res;
        bit   ok;
        set_pattern(3, 2);
        d0 = done_cnt;
        sb.push_back(model(3, 2));
        pulse_start();
        n_chk++;
        if (timeout !== 1'b0) $display("FAIL timeout_cleared_at_start: got %b want 0", timeout);
        else n_pass++;
        pulse_start();
        repeat (4) @(negedge sys_clk);
        n_chk++;
        if (busy !== 1'b1) $display("FAIL busy_in_meas: got %b want 1", busy);
        else n_pass++;
        pulse_start();
        wait_done(2 * 5 + SYNC_STAGES + 2, ok);
        e_res = sb.pop_front();
        g_res = cur_res();
        n_chk++;
        if (!ok || g_res !== e_res)
            $display("FAIL ignored_start_result: got done=%b p=%0d h=%0d r=%b d=%b t=%b, want p=%0d h=%0d r=%b d=%b t=%b",
                     ok, g_res.period, g_res.high, g_res.ratio, g_res.duty, g_res.tmo,
                     e_res.period, e_res.high, e_res.ratio, e_res.duty, e_res.tmo);
        else n_pass++;
        repeat (15) @(negedge sys_clk);
        n_chk++;
        if (done_cnt - d0 != 1) $display("FAIL ignored_start_done_count: got %0d want 1", done_cnt - d0);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int   d0;
        res_t e_res;
        res_t g_res;
        bit   ok;
        set_pattern(2, 2);
        d0 = done_cnt;
        sb.push_back(model(2, 2));
        sb.push_back(model(2, 2));
        start = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_done(2 * 4 + SYNC_STAGES + 4, ok);
            if (k == 1) start = 1'b0;
            e_res = sb.pop_front();
            g_res = cur_res();
            n_chk++;
            if (!ok || g_res !== e_res)
                $display("FAIL back_to_back[%0d]: got done=%b p=%0d h=%0d r=%b d=%b t=%b, want p=%0d h=%0d r=%b d=%b t=%b",
                         k, ok, g_res.period, g_res.high, g_res.ratio, g_res.duty, g_res.tmo,
                         e_res.period, e_res.high, e_res.ratio, e_res.duty, e_res.tmo);
            else n_pass++;
            @(negedge sys_clk);
        end
        start = 1'b0;
        repeat (12) @(negedge sys_clk);
        n_chk++;
        if (done_cnt - d0 != 2 || busy !== 1'b0)
            $display("FAIL back_to_back_count: got dones=%0d busy=%b, want dones=2 busy=0", done_cnt - d0, busy);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_ratio_duty();
        test_async_reset();
        test_timeout();
        test_ignored_start();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_chk);
        $fatal(1);
    end

endmodule

`default_nettype wire
